// File: rtl/hm_ctrl_pkg.sv
// rtl/hm_ctrl_pkg.sv - shared state encodings and CSR register indices for hm_ctrl
package hm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LINK = 3'd1,
    ST_RUN       = 3'd2,
    ST_BACKOFF   = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } hm_state_e;

  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_STATUS     = 3'd1;
  localparam logic [2:0] REG_SNAP_RX    = 3'd2;
  localparam logic [2:0] REG_SNAP_TX    = 3'd3;
  localparam logic [2:0] REG_SNAP_DROP  = 3'd4;
  localparam logic [2:0] REG_RUN_CYCLES = 3'd5;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int STAT_DONE_BIT   = 3;
  localparam int STAT_ERR_BIT    = 4;

  function automatic logic [31:0] status_word(input logic [3:0] retry, input logic err,
                                              input logic done, input hm_state_e st);
    return {23'd0, retry, err, done, st};
  endfunction

endpackage

// File: rtl/hm_ctrl.sv
// rtl/hm_ctrl.sv - run/retry/backoff controller with CSR bank, stat snapshots and irq
module hm_ctrl
  import hm_ctrl_pkg::*;
#(
  parameter logic [3:0]  csr_addr  = 4'h0,
  parameter int unsigned retry_max = 3,
  parameter int unsigned backoff   = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  output logic        hm_start,
  output logic        hm_abort,
  input  logic        hm_end,
  input  logic        rx_timeout,
  input  logic        tx_timeout,
  input  logic        trn_lnk_up_n,
  input  logic [31:0] stat_cpt_rx,
  input  logic [31:0] stat_cpt_tx,
  input  logic [31:0] stat_cpt_drop
);

  localparam logic [3:0]  RETRY_MAX = retry_max[3:0];
  localparam logic [15:0] BO_LAST   = 16'(backoff - 1);

  hm_state_e   state_q, state_d;
  logic [31:0] csr_do_q, csr_do_d;
  logic        irq_q, irq_d;
  logic        hm_start_q, hm_start_d;
  logic        hm_abort_q, hm_abort_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        irq_en_q, irq_en_d;
  logic [3:0]  retry_cnt_q, retry_cnt_d;
  logic [15:0] bo_cnt_q, bo_cnt_d;
  logic [31:0] snap_rx_q, snap_rx_d;
  logic [31:0] snap_tx_q, snap_tx_d;
  logic [31:0] snap_drop_q, snap_drop_d;
  logic [31:0] run_cycles_q, run_cycles_d;

  logic       sel, ctrl_wr, stat_wr, start_wr, abort_wr;
  logic [2:0] idx;
  logic       unused_bits;

  assign unused_bits = ^{csr_a[9:3], csr_di[31:5]};

  always_comb begin
    sel      = (csr_a[13:10] == csr_addr);
    idx      = csr_a[2:0];
    ctrl_wr  = csr_we && sel && (idx == REG_CTRL);
    stat_wr  = csr_we && sel && (idx == REG_STATUS);
    start_wr = ctrl_wr && csr_di[CTRL_START_BIT];
    abort_wr = ctrl_wr && csr_di[CTRL_ABORT_BIT];

    state_d      = state_q;
    hm_abort_d   = 1'b0;
    done_d       = done_q;
    err_d        = err_q;
    irq_en_d     = irq_en_q;
    retry_cnt_d  = retry_cnt_q;
    bo_cnt_d     = bo_cnt_q;
    snap_rx_d    = snap_rx_q;
    snap_tx_d    = snap_tx_q;
    snap_drop_d  = snap_drop_q;
    run_cycles_d = run_cycles_q;

    if (ctrl_wr) irq_en_d = csr_di[CTRL_IRQ_EN_BIT];
    if (stat_wr && csr_di[STAT_DONE_BIT]) done_d = 1'b0;
    if (stat_wr && csr_di[STAT_ERR_BIT])  err_d  = 1'b0;

    if ((state_q == ST_RUN || state_q == ST_BACKOFF) && run_cycles_q != 32'hFFFF_FFFF)
      run_cycles_d = run_cycles_q + 32'd1;

    // Priority within each state: abort write, then link down, then hm_end, then timeout.
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (abort_wr && state_q != ST_IDLE) begin
          hm_abort_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (start_wr) begin
          done_d       = 1'b0;
          err_d        = 1'b0;
          retry_cnt_d  = 4'd0;
          run_cycles_d = 32'd0;
          state_d      = trn_lnk_up_n ? ST_WAIT_LINK : ST_RUN;
        end
      end
      ST_WAIT_LINK: begin
        if (abort_wr) begin
          hm_abort_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (!trn_lnk_up_n) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_wr) begin
          hm_abort_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (trn_lnk_up_n) begin
          hm_abort_d = 1'b1;
          err_d      = 1'b1;
          state_d    = ST_ERROR;
        end else if (hm_end) begin
          snap_rx_d   = stat_cpt_rx;
          snap_tx_d   = stat_cpt_tx;
          snap_drop_d = stat_cpt_drop;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else if (rx_timeout || tx_timeout) begin
          if (retry_cnt_q < RETRY_MAX) begin
            hm_abort_d  = 1'b1;
            retry_cnt_d = retry_cnt_q + 4'd1;
            bo_cnt_d    = 16'd0;
            state_d     = ST_BACKOFF;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      ST_BACKOFF: begin
        if (abort_wr) begin
          hm_abort_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (trn_lnk_up_n) begin
          hm_abort_d = 1'b1;
          err_d      = 1'b1;
          state_d    = ST_ERROR;
        end else if (bo_cnt_q == BO_LAST) begin
          state_d = ST_RUN;
        end else begin
          bo_cnt_d = bo_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    hm_start_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    irq_d      = irq_en_d && (done_d || err_d);

    csr_do_d = 32'd0;
    if (sel) begin
      case (idx)
        REG_CTRL:       csr_do_d = {29'd0, irq_en_q, 2'b00};
        REG_STATUS:     csr_do_d = status_word(retry_cnt_q, err_q, done_q, state_q);
        REG_SNAP_RX:    csr_do_d = snap_rx_q;
        REG_SNAP_TX:    csr_do_d = snap_tx_q;
        REG_SNAP_DROP:  csr_do_d = snap_drop_q;
        REG_RUN_CYCLES: csr_do_d = run_cycles_q;
        default:        csr_do_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      csr_do_q     <= 32'd0;
      irq_q        <= 1'b0;
      hm_start_q   <= 1'b0;
      hm_abort_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      retry_cnt_q  <= 4'd0;
      bo_cnt_q     <= 16'd0;
      snap_rx_q    <= 32'd0;
      snap_tx_q    <= 32'd0;
      snap_drop_q  <= 32'd0;
      run_cycles_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      csr_do_q     <= csr_do_d;
      irq_q        <= irq_d;
      hm_start_q   <= hm_start_d;
      hm_abort_q   <= hm_abort_d;
      done_q       <= done_d;
      err_q        <= err_d;
      irq_en_q     <= irq_en_d;
      retry_cnt_q  <= retry_cnt_d;
      bo_cnt_q     <= bo_cnt_d;
      snap_rx_q    <= snap_rx_d;
      snap_tx_q    <= snap_tx_d;
      snap_drop_q  <= snap_drop_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign csr_do   = csr_do_q;
  assign irq      = irq_q;
  assign hm_start = hm_start_q;
  assign hm_abort = hm_abort_q;

endmodule

// File: doc/hm_ctrl.md
HM_CTRL -- requirements
Module: hm_ctrl

Interface
REQ-001 SHALL have parameter csr_addr, default 4'h0, the CSR bank select compared against csr_a[13:10].
REQ-002 SHALL have parameter retry_max, default 3, the number of timeout retries before ERROR.
REQ-003 SHALL have parameter backoff, default 256, the wait in cycles between an abort and a restart.
REQ-004 SHALL have ports: sys_clk in 1, single clock; sys_rst in 1, asynchronous active-high reset.
REQ-005 SHALL have ports: csr_a in 14, CSR address; csr_we in 1, write strobe; csr_di in 32, write data; csr_do out 32, registered read data.
REQ-006 SHALL have ports: irq out 1, level interrupt; hm_start out 1, one-cycle run pulse; hm_abort out 1, one-cycle abort pulse.
REQ-007 SHALL have ports: hm_end in 1, run-complete pulse; rx_timeout in 1 and tx_timeout in 1, timeout pulses; trn_lnk_up_n in 1, link down level; all already synchronised to sys_clk.
REQ-008 SHALL have ports: stat_cpt_rx in 32, stat_cpt_tx in 32, stat_cpt_drop in 32, free-running datapath counters.

Function
REQ-009 SHALL decode the CSR bank as selected when csr_a[13:10]==csr_addr, and the register index as csr_a[2:0].
REQ-010 SHALL place registers at: 0 CTRL (bit0 start W1P, bit1 abort W1P, bit2 irq_en RW); 1 STATUS ({retry_cnt[3:0], err, done, state[2:0]}, with write-1 to bits 3/4 clearing done/err); 2 SNAP_RX; 3 SNAP_TX; 4 SNAP_DROP; 5 RUN_CYCLES.
REQ-011 SHALL register csr_do one cycle after the address is presented, and drive 0 when the bank is not selected or the index is 6-7.
REQ-012 SHALL implement the states IDLE=0, WAIT_LINK=1, RUN=2, BACKOFF=3, DONE=4, ERROR=5.
REQ-013 SHALL, in IDLE, DONE or ERROR on a start write, clear done, err, retry_cnt and RUN_CYCLES, then go to WAIT_LINK if trn_lnk_up_n=1, else go to RUN.
REQ-014 SHALL, in WAIT_LINK, go to RUN in the first cycle trn_lnk_up_n=0.
REQ-015 SHALL assert hm_start for exactly the first cycle of every RUN entry.
REQ-016 SHALL, in RUN, on hm_end, copy the three stat inputs into SNAP_*, set done and go to DONE.
REQ-017 SHALL, in RUN, on rx_timeout or tx_timeout: if retry_cnt<retry_max, pulse hm_abort, increment retry_cnt and go to BACKOFF; otherwise set err and go to ERROR.
REQ-018 SHALL, in RUN or BACKOFF, on trn_lnk_up_n=1, pulse hm_abort, set err and go to ERROR.
REQ-019 SHALL, in BACKOFF, count backoff cycles and then return to RUN.
REQ-020 SHALL apply priority: CTRL abort write > link down > hm_end > timeout.
REQ-021 SHALL, on an abort write in any non-IDLE state, pulse hm_abort, go to IDLE, and leave done/err unchanged.
REQ-022 SHALL ignore a start write in WAIT_LINK, RUN or BACKOFF.
REQ-023 SHALL increment RUN_CYCLES on each cycle in RUN or BACKOFF, saturating at 32'hFFFFFFFF.
REQ-024 SHALL drive irq = irq_en & (done | err), registered.

Reset
REQ-025 SHALL, on sys_rst, immediately set state=IDLE and set csr_do, irq, hm_start, hm_abort, done, err, irq_en, retry_cnt, the backoff counter, SNAP_* and RUN_CYCLES to 0.
REQ-026 SHALL not emit hm_start or hm_abort in the cycle following reset deassertion.

Structure
REQ-027 SHALL put the state encodings and register indices 0-5 in a shared hm package header used by the driver and the bench.
REQ-028 SHALL contain no sub-modules; the FSM, CSR decode and counters live in one file.

Verification
REQ-029 Bench SHALL cover: link up, start write, hm_end after 50 cycles -> one hm_start pulse, STATUS done=1 state=4, SNAP_RX equals stat_cpt_rx at the hm_end cycle, RUN_CYCLES=50.
REQ-030 Bench SHALL cover: retry_max=3 with four rx_timeout pulses, each after the restart -> three hm_abort pulses each followed by 256 cycles then hm_start, then err=1, state=5, retry_cnt=3.
REQ-031 Bench SHALL cover: trn_lnk_up_n=1 at start, released after 20 cycles -> state=1 for 20 cycles, then hm_start; later a link drop in RUN -> hm_abort, err=1.
REQ-032 Bench SHALL cover: hm_end and tx_timeout in the same cycle -> DONE, no hm_abort, retry_cnt=0.
REQ-033 Bench SHALL cover: irq_en=1 with DONE reached -> irq=1; writing STATUS bit3 -> irq=0 the next cycle; a CSR read with csr_a[13:10]!=csr_addr -> csr_do=0.
REQ-034 Bench SHALL cover: sys_rst asserted mid-BACKOFF -> all outputs 0 asynchronously, and no hm_start after release until a new start write.
